// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stage feeding the serial sequence detector.
// Words enter through load/ready and leave one bit per enabled clock on x/x_valid.
//
// state | meaning
// IDLE  | no word in flight, ready for a new word
// SHIFT | word in flight, x carries the current bit
module seq_bit_serializer #(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             out_bit;

  // Final bit is consumed on this edge; also the window for a back-to-back load.
  assign last_bit = (state == SHIFT) && (cnt == LAST) && en;
  assign ready    = (state == IDLE) || last_bit;

  assign out_bit  = MSB_FIRST ? sh[WIDTH-1] : sh[0];
  assign x_valid  = (state == SHIFT);
  assign busy     = (state == SHIFT);
  assign x        = (state == SHIFT) && out_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= last_bit;
      case (state)
        IDLE: begin
          if (load) begin
            sh    <= data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (en) begin
            if (cnt == LAST) begin
              cnt <= '0;
              if (load) begin
                sh <= data;
              end else begin
                sh    <= '0;
                state <= IDLE;
              end
            end else begin
              sh  <= MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: MSB-first and LSB-first instances share stimulus.
// The driver models word acceptance and pushes expected bits; a negedge monitor checks them.
module tb_seq_bit_serializer;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] data = '0;
  logic         en = 1'b0;

  logic ready1, x1, x_valid1, busy1, done1;
  logic ready0, x0, x_valid0, busy0, done0;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .load(load), .data(data), .en(en),
    .ready(ready1), .x(x1), .x_valid(x_valid1), .busy(busy1), .done(done1));

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load(load), .data(data), .en(en),
    .ready(ready0), .x(x0), .x_valid(x_valid0), .busy(busy0), .done(done0));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: bits of each accepted word, in the order they must appear.
  logic q_msb[$];
  logic q_lsb[$];
  int   rem = 0;
  logic exp_done = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs settled mid-cycle; en for the coming edge is already driven.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_ready;
      exp_ready = (rem == 0) || (rem == 1 && en);
      chk("ready_msb", ready1, exp_ready);
      chk("ready_lsb", ready0, exp_ready);
      chk("valid_msb", x_valid1, rem > 0);
      chk("valid_lsb", x_valid0, rem > 0);
      chk("busy_msb", busy1, rem > 0);
      chk("busy_lsb", busy0, rem > 0);
      chk("done_msb", done1, exp_done);
      chk("done_lsb", done0, exp_done);
      if (rem > 0) begin
        if (q_msb.size() == 0 || q_lsb.size() == 0) begin
          chk("queue_underflow", 1'b1, 1'b0);
        end else begin
          chk("x_msb", x1, q_msb[0]);
          chk("x_lsb", x0, q_lsb[0]);
          if (en) begin
            void'(q_msb.pop_front());
            void'(q_lsb.pop_front());
          end
        end
      end else begin
        chk("x_idle_msb", x1, 1'b0);
        chk("x_idle_lsb", x0, 1'b0);
      end
    end
  end

  // One clock of stimulus; the model advances on the edge, inputs change 1ns later.
  task automatic step(input logic ld, input logic [W-1:0] d, input logic e, output logic acc);
    logic mready;
    load = ld;
    data = d;
    en   = e;
    @(posedge clk);
    mready   = (rem == 0) || (rem == 1 && en);
    acc      = load && mready;
    exp_done = (rem == 1) && en;
    if (rem > 0 && en) rem--;
    if (acc) begin
      rem = W;
      for (int i = W - 1; i >= 0; i--) q_msb.push_back(data[i]);
      for (int i = 0; i < W; i++) q_lsb.push_back(data[i]);
    end
    #1;
  endtask

  task automatic idle_steps(input int n, input int en_mode);
    logic acc;
    for (int i = 0; i < n; i++) begin
      logic e;
      e = (en_mode == 1) ? 1'b1 : (($urandom % 4) != 0);
      step(1'b0, '0, e, acc);
    end
  endtask

  // Hold load until the model says the word was taken; en random unless forced on.
  task automatic send_word(input logic [W-1:0] d, input logic en_on);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 4 * W) begin
      logic e;
      e = en_on ? 1'b1 : (($urandom % 4) != 0);
      step(1'b1, d, e, acc);
      n++;
    end
    if (!acc) chk("load_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rem > 0 && n < 8 * W) begin
      idle_steps(1, 1);
      n++;
    end
    idle_steps(2, 1);
  endtask

  initial begin
    logic acc;
    #3;
    chk("rst_ready", ready1, 1'b1);
    chk("rst_valid", x_valid1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_x", x1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle_steps(2, 1);

    // plain word, en held
    send_word(10'b0001111010, 1'b1);
    drain();

    // stall: two consumed bits, then three stalled cycles
    send_word(10'b0001111010, 1'b1);
    step(1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b0, acc);
    step(1'b0, '0, 1'b0, acc);
    step(1'b0, '0, 1'b0, acc);
    drain();

    // back-to-back: second word offered right away, taken on the last bit
    send_word(10'h3FF, 1'b1);
    send_word(10'h000, 1'b1);
    drain();

    // load while busy is ignored
    send_word(10'h2A3, 1'b1);
    step(1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);
    step(1'b1, 10'h155, 1'b1, acc);
    chk("busy_load_ignored", acc, 1'b0);
    drain();

    // async reset mid-word
    send_word(10'h1C7, 1'b1);
    idle_steps(4, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", x_valid1, 1'b0);
    chk("arst_busy", busy1, 1'b0);
    chk("arst_x", x1, 1'b0);
    chk("arst_ready", ready1, 1'b1);
    chk("arst_done", done1, 1'b0);
    q_msb.delete();
    q_lsb.delete();
    rem = 0;
    exp_done = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_done_held", done1, 1'b0);
    rst = 1'b0;
    send_word(10'h2B5, 1'b1);
    drain();

    // random words, random stalls and gaps
    for (int k = 0; k < 40; k++) begin
      send_word(W'($urandom), 1'b0);
      idle_steps($urandom % 4, 0);
    end
    drain();

    chk("queue_empty_msb", q_msb.size() == 0, 1'b1);
    chk("queue_empty_lsb", q_lsb.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Parallel-to-serial stage placed directly upstream of the team's serial sequence detector.
- Accepts a WIDTH-bit pattern word through a load/ready handshake.
- Shifts the word out one bit per enabled clock on `x`, qualified by `x_valid`, and pulses `done` when the word is exhausted.
- Supports consumer stalls through `en` and back-to-back words with no idle bubble.

Parameters:
- WIDTH, 10, number of bits per word (legal range 2 to 64).
- MSB_FIRST, 1, 1 = shift out data[WIDTH-1] first; 0 = shift out data[0] first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load  input  1  request to accept `data`; honoured only when `ready`=1
- data  input  WIDTH  word to serialize; sampled on the clk edge where load&ready=1
- en  input  1  consumer advance; the current bit is consumed on an edge where x_valid&en=1
- ready  output  1  block can accept a word this cycle
- x  output  1  current serial bit; 0 when x_valid=0
- x_valid  output  1  `x` carries a valid bit
- busy  output  1  a word is in flight (state SHIFT)
- done  output  1  one-cycle pulse, registered, the cycle after the last bit of a word is consumed

Behaviour:
- Reset (async, immediate):
  - state=IDLE, shift register=0, bit counter=0.
  - Outputs: x=0, x_valid=0, busy=0, done=0, ready=1.
- Internal registers:
  - shift register sh[WIDTH-1:0].
  - counter cnt of width $clog2(WIDTH).
  - state {IDLE, SHIFT}.
- IDLE:
  - ready=1, x_valid=0, x=0.
  - On load=1: sh<=data, cnt<=0, state<=SHIFT.
  - Latency: the first bit is valid on `x` in the cycle after the load edge.
- SHIFT:
  - x_valid=1, busy=1.
  - x = sh[WIDTH-1] when MSB_FIRST=1, else sh[0]. `x` is a pure function of registers (no combinational path from inputs).
  - en=0: hold sh and cnt; `x` stays stable (stall).
  - en=1 and cnt<WIDTH-1: shift sh toward the output end (zero-fill), cnt<=cnt+1.
  - en=1 and cnt==WIDTH-1: last bit consumed; done<=1 next cycle.
    - If load=1 on the same edge: sh<=data, cnt<=0, stay in SHIFT (back-to-back, no gap bit).
    - Otherwise: state<=IDLE.
- ready:
  - ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1 & en).
  - This path is combinational from `en`; it is the only combinational input-to-output path.
- load while ready=0 is ignored, with no side effects. The upstream producer must hold `load` until it sees `ready`.
- done is registered, exactly one cycle wide per word, and is independent of whether the next word was loaded.
- Stream timing:
  - With en held 1, a word occupies exactly WIDTH consecutive x_valid cycles.
  - Throughput is one bit per clock.
- Counter never exceeds WIDTH-1; there is no wrap beyond a word.
- Reset mid-word:
  - Word is abandoned immediately and outputs return to reset values.
  - No done pulse for the abandoned word.
  - After reset release, the first load starts a fresh word.
- `data` changes after the load edge have no effect on the word in flight.

Test Plan:
1. Reset, then load=1 with data=10'b0001111010, MSB_FIRST=1, en=1 held -> `x` over cycles 1..10 = 0,0,0,1,1,1,1,0,1,0 with x_valid=1 throughout; done=1 only in cycle 11; ready=0 in cycles 1..9 and 1 in cycle 10; back in IDLE with ready=1 from cycle 11.
2. Same word with MSB_FIRST=0 -> `x` = 0,1,0,1,1,1,1,0,0,0; done in cycle 11.
3. Stall: as test 1 but en=0 in cycles 3-5 -> `x` holds 0 (bit 2) through cycles 3..6, then continues 1,1,1,1,0,1,0; total 13 valid cycles; done in cycle 14.
4. Back-to-back: first word 10'h3FF, second word 10'h000 presented with load=1 in cycle 10 -> 10 ones then 10 zeros with no x_valid gap; done in cycles 11 and 21.
5. Load while busy: load=1 with data=10'h155 in cycle 4 of a word -> ignored; the original word completes unchanged; after done, x_valid=0.
6. Async reset in cycle 6 of a word -> x, x_valid and busy drop to 0 without waiting for a clock edge; no done pulse; ready=1; a subsequent load emits the new word from its first bit.
